// File: rtl/adder_resp_checker_if.sv
// Result-side bus of the registered adder: operands, adder results, status.
// The master drives operands and adder results; the checker is the slave.
interface adder_resp_checker_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) ();
  logic             en;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             chk_valid;
  logic             mismatch;
  logic             err_flag;
  logic [WIDTH:0]   exp_result;
  logic [CNT_W-1:0] pass_count;
  logic [CNT_W-1:0] err_count;
  logic             halted;

  modport master (
    output en,
    output a,
    output b,
    output cin,
    output sum,
    output carry,
    input  chk_valid,
    input  mismatch,
    input  err_flag,
    input  exp_result,
    input  pass_count,
    input  err_count,
    input  halted
  );

  modport slave (
    input  en,
    input  a,
    input  b,
    input  cin,
    input  sum,
    input  carry,
    output chk_valid,
    output mismatch,
    output err_flag,
    output exp_result,
    output pass_count,
    output err_count,
    output halted
  );
endinterface

// File: rtl/adder_resp_checker.sv
// Response checker for the registered adder: delays the expected
// {carry,sum} by the adder latency and compares it with the result.
module adder_resp_checker #(
  parameter int WIDTH       = 4,
  parameter int LATENCY     = 1,
  parameter int CNT_W       = 8,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  adder_resp_checker_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_HALT
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LATENCY-1:0] r_vld;
  logic [WIDTH:0]     r_exp [LATENCY];

  logic               r_chk;
  logic               r_mm;
  logic               r_err;
  logic [WIDTH:0]     r_exp_res;
  logic [CNT_W-1:0]   r_pass;
  logic [CNT_W-1:0]   r_errc;

  logic [WIDTH:0]     w_sample;
  logic [WIDTH:0]     w_obs;
  logic               w_cmp;
  logic               w_bad;
  logic               w_busy;

  // Full-width sum so the carry out is never lost.
  assign w_sample = {1'b0, bus.a}
                  + {1'b0, bus.b}
                  + {{WIDTH{1'b0}}, bus.cin};

  assign w_obs  = {bus.carry, bus.sum};
  assign w_cmp  = r_vld[LATENCY-1]
               && (r_state == S_CHECK);
  assign w_bad  = w_cmp
               && (w_obs != r_exp[LATENCY-1]);
  assign w_busy = (|r_vld) || bus.en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.en) w_state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (STOP_ON_ERR && w_bad) begin
          w_state_nxt = S_HALT;
        end else if (!w_busy) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    if (clr) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_exp[i] <= '0;
      end
    end else if (clr) begin
      r_vld <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_exp[i] <= '0;
      end
    end else begin
      r_vld[0] <= bus.en;
      r_exp[0] <= w_sample;
      for (int i = 1; i < LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_exp[i] <= r_exp[i-1];
      end
    end
  end

  // Counters saturate; HALT blocks updates via w_cmp.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk     <= 1'b0;
      r_mm      <= 1'b0;
      r_err     <= 1'b0;
      r_exp_res <= '0;
      r_pass    <= '0;
      r_errc    <= '0;
    end else if (clr) begin
      r_chk     <= 1'b0;
      r_mm      <= 1'b0;
      r_err     <= 1'b0;
      r_exp_res <= '0;
      r_pass    <= '0;
      r_errc    <= '0;
    end else begin
      r_chk <= w_cmp;
      r_mm  <= w_bad;
      if (w_cmp) begin
        r_exp_res <= r_exp[LATENCY-1];
        if (w_bad) begin
          r_err <= 1'b1;
          if (r_errc != '1) begin
            r_errc <= r_errc + 1'b1;
          end
        end else if (r_pass != '1) begin
          r_pass <= r_pass + 1'b1;
        end
      end
    end
  end

  assign bus.chk_valid  = r_chk;
  assign bus.mismatch   = r_mm;
  assign bus.err_flag   = r_err;
  assign bus.exp_result = r_exp_res;
  assign bus.pass_count = r_pass;
  assign bus.err_count  = r_errc;
  assign bus.halted     = (r_state == S_HALT);

endmodule

// File: tb/tb_adder_resp_checker.sv
// Bench for adder_resp_checker: two configurations fed by adder models,
// checked against a per-sample history model of expected comparisons.
module tb_adder_resp_checker;

  localparam int W  = 4;
  localparam int LA = 1;
  localparam int LB = 3;
  localparam int CA = 8;
  localparam int CB = 2;
  localparam int N  = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  logic inj_a = 1'b0;
  logic inj_b = 1'b0;

  always #5 clk = ~clk;

  adder_resp_checker_if #(.WIDTH(W), .CNT_W(CA)) bus_a ();
  adder_resp_checker_if #(.WIDTH(W), .CNT_W(CB)) bus_b ();

  adder_resp_checker #(
    .WIDTH(W), .LATENCY(LA), .CNT_W(CA), .STOP_ON_ERR(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst), .clr(clr_a), .bus(bus_a.slave)
  );

  adder_resp_checker #(
    .WIDTH(W), .LATENCY(LB), .CNT_W(CB), .STOP_ON_ERR(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .clr(clr_b), .bus(bus_b.slave)
  );

  // Adder models: inj forces the registered result to zero.
  logic [W:0] pa;
  logic [W:0] pb [LB];

  always @(posedge clk) begin
    pa <= inj_a ? 5'd0
        : 5'(bus_a.a) + 5'(bus_a.b) + 5'(bus_a.cin);
    pb[0] <= inj_b ? 5'd0
        : 5'(bus_b.a) + 5'(bus_b.b) + 5'(bus_b.cin);
    pb[1] <= pb[1-1];
    pb[2] <= pb[2-1];
  end

  assign {bus_a.carry, bus_a.sum} = pa;
  assign {bus_b.carry, bus_b.sum} = pb[LB-1];

  int passed = 0;
  int total  = 0;
  int n      = 0;

  int lat  [2] = '{LA, LB};
  int cmax [2] = '{(1 << CA) - 1, (1 << CB) - 1};
  bit stop [2] = '{1'b0, 1'b1};

  bit         h_en  [2][N];
  logic [4:0] h_exp [2][N];
  bit         h_bad [2][N];
  bit         h_clr [2][N];

  int         floor_i [2];
  int         m_pass  [2];
  int         m_err   [2];
  bit         m_flag  [2];
  bit         m_halt  [2];
  bit         m_cv    [2];
  bit         m_mm    [2];
  logic [4:0] m_exp   [2];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h, expected %0h",
                tag, obs, exp);
  endtask

  task automatic zero_model(input int d, input int fl);
    floor_i[d] = fl;
    m_pass[d]  = 0;
    m_err[d]   = 0;
    m_flag[d]  = 1'b0;
    m_halt[d]  = 1'b0;
    m_cv[d]    = 1'b0;
    m_mm[d]    = 1'b0;
    m_exp[d]   = 5'd0;
  endtask

  task automatic drive(input int d, input bit e,
                       input logic [3:0] x, input logic [3:0] y,
                       input bit c, input bit inj, input bit cl);
    int idx;
    idx = n + 1;
    h_en[d][idx]  = e;
    h_exp[d][idx] = 5'(x) + 5'(y) + 5'(c);
    h_bad[d][idx] = inj && (h_exp[d][idx] != 5'd0);
    h_clr[d][idx] = cl;
    if (d == 0) begin
      bus_a.en = e; bus_a.a = x; bus_a.b = y;
      bus_a.cin = c; inj_a = inj; clr_a = cl;
    end else begin
      bus_b.en = e; bus_b.a = x; bus_b.b = y;
      bus_b.cin = c; inj_b = inj; clr_b = cl;
    end
  endtask

  task automatic idle_both();
    drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic rnd(input int d, input bit inj, input bit cl);
    drive(d, 1'b1, 4'($urandom), 4'($urandom),
          1'($urandom), inj, cl);
  endtask

  task automatic upd(input int d);
    int k;
    if (h_clr[d][n]) begin
      zero_model(d, n + 1);
    end else begin
      m_cv[d] = 1'b0;
      m_mm[d] = 1'b0;
      k = n - lat[d];
      if (k >= floor_i[d] && h_en[d][k] && !m_halt[d]) begin
        m_cv[d]  = 1'b1;
        m_mm[d]  = h_bad[d][k];
        m_exp[d] = h_exp[d][k];
        if (m_mm[d]) begin
          m_flag[d] = 1'b1;
          if (m_err[d] < cmax[d]) m_err[d]++;
          if (stop[d]) m_halt[d] = 1'b1;
        end else if (m_pass[d] < cmax[d]) begin
          m_pass[d]++;
        end
      end
    end
  endtask

  task automatic cmp_out(input int d);
    logic [31:0] cv, mm, ef, er, pc, ec, ht;
    if (d == 0) begin
      cv = 32'(bus_a.chk_valid);  mm = 32'(bus_a.mismatch);
      ef = 32'(bus_a.err_flag);   er = 32'(bus_a.exp_result);
      pc = 32'(bus_a.pass_count); ec = 32'(bus_a.err_count);
      ht = 32'(bus_a.halted);
    end else begin
      cv = 32'(bus_b.chk_valid);  mm = 32'(bus_b.mismatch);
      ef = 32'(bus_b.err_flag);   er = 32'(bus_b.exp_result);
      pc = 32'(bus_b.pass_count); ec = 32'(bus_b.err_count);
      ht = 32'(bus_b.halted);
    end
    chk($sformatf("d%0d_chk_valid@%0d", d, n), cv, 32'(m_cv[d]));
    chk($sformatf("d%0d_mismatch@%0d", d, n), mm, 32'(m_mm[d]));
    chk($sformatf("d%0d_err_flag@%0d", d, n), ef, 32'(m_flag[d]));
    chk($sformatf("d%0d_exp_result@%0d", d, n), er, 32'(m_exp[d]));
    chk($sformatf("d%0d_pass_count@%0d", d, n), pc, 32'(m_pass[d]));
    chk($sformatf("d%0d_err_count@%0d", d, n), ec, 32'(m_err[d]));
    chk($sformatf("d%0d_halted@%0d", d, n), ht, 32'(m_halt[d]));
  endtask

  task automatic tick();
    @(posedge clk);
    n = n + 1;
    #1;
    upd(0);
    upd(1);
    cmp_out(0);
    cmp_out(1);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    #2;
    zero_model(0, n + 1);
    zero_model(1, n + 1);
    cmp_out(0);
    cmp_out(1);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    zero_model(0, 1);
    zero_model(1, 1);
    idle_both();
    #20;
    cmp_out(0);
    cmp_out(1);
    #30;
    rst = 1'b0;

    drive(0, 1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    tick();
    idle_both();
    tick();
    chk("a_first_cv", 32'(bus_a.chk_valid), 32'd1);
    chk("a_first_exp", 32'(bus_a.exp_result), 32'h10);
    chk("a_first_pass", 32'(bus_a.pass_count), 32'd1);

    for (int i = 0; i < 16; i++) begin
      rnd(0, 1'b0, 1'b0);
      rnd(1, 1'b0, 1'b0);
      tick();
    end
    repeat (3) begin
      idle_both();
      tick();
    end
    chk("a_stream_pass", 32'(bus_a.pass_count), 32'd17);
    chk("a_stream_err", 32'(bus_a.err_count), 32'd0);
    chk("b_sat_pass", 32'(bus_b.pass_count), 32'd3);

    drive(0, 1'b1, 4'h3, 4'h4, 1'b0, 1'b1, 1'b0);
    rnd(1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rnd(1, 1'b0, 1'b0);
    tick();
    chk("a_inj_mm", 32'(bus_a.mismatch), 32'd1);
    chk("a_inj_exp", 32'(bus_a.exp_result), 32'h07);
    chk("a_inj_errc", 32'(bus_a.err_count), 32'd1);

    for (int i = 0; i < 6; i++) begin
      drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      if (i == 2) drive(1, 1'b1, 4'h3, 4'h4, 1'b0, 1'b1, 1'b0);
      else rnd(1, 1'b0, 1'b0);
      tick();
    end
    repeat (4) begin
      idle_both();
      tick();
    end
    chk("a_flag_sticky", 32'(bus_a.err_flag), 32'd1);
    chk("b_halted", 32'(bus_b.halted), 32'd1);
    chk("b_halt_errc", 32'(bus_b.err_count), 32'd1);
    chk("b_halt_cv", 32'(bus_b.chk_valid), 32'd0);

    rnd(0, 1'b0, 1'b1);
    rnd(1, 1'b0, 1'b1);
    tick();
    chk("b_clr_halted", 32'(bus_b.halted), 32'd0);
    chk("a_clr_flag", 32'(bus_a.err_flag), 32'd0);
    idle_both();
    tick();

    drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rnd(1, 1'b0, 1'b0);
    tick();
    drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    rnd(1, 1'b0, 1'b0);
    tick();
    do_rst();
    repeat (4) begin
      idle_both();
      tick();
    end
    chk("b_rst_pass", 32'(bus_b.pass_count), 32'd0);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      rnd(1, 1'b0, 1'b0);
      tick();
    end
    repeat (4) begin
      idle_both();
      tick();
    end
    chk("b_post_rst_pass", 32'(bus_b.pass_count), 32'd2);

    for (int i = 0; i < 300; i++) begin
      for (int d = 0; d < 2; d++) begin
        drive(d, ($urandom_range(0, 3) != 0),
              4'($urandom), 4'($urandom), 1'($urandom),
              ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 39) == 0));
      end
      tick();
    end
    repeat (4) begin
      idle_both();
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
